// File: rtl/inst_enc.sv
// RV32I instruction encoder: packs micro-op fields into 32-bit words with byte addresses.
// Optional immediate range checking is enabled by defining ENC_RANGE_CHECK_EN.
module inst_enc #(
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic [15:0]       word_cnt,
    output logic              err
);

    localparam logic [2:0]  OP_ADD  = 3'd0;
    localparam logic [2:0]  OP_SUB  = 3'd1;
    localparam logic [2:0]  OP_ADDI = 3'd2;
    localparam logic [2:0]  OP_BNE  = 3'd3;
    localparam logic [2:0]  OP_JAL  = 3'd4;
    localparam logic [2:0]  OP_LUI  = 3'd5;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W-1:0] addr_now;
    logic [31:0]       enc_inst;
    logic              enc_bad;
    logic              range_bad;
    logic              capture;

    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready;
    // A same-cycle clear restarts the sequence before the captured word takes its address.
    assign addr_now = clear ? BASE_ADDR : addr_cnt;

`ifdef ENC_RANGE_CHECK_EN
    always_comb begin
        range_bad = 1'b0;
        case (in_op)
            OP_ADDI: range_bad = !((&in_imm[31:11]) || !(|in_imm[31:11]));
            OP_BNE:  range_bad = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
            OP_JAL:  range_bad = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
            OP_LUI:  range_bad = |in_imm[11:0];
            default: range_bad = 1'b0;
        endcase
    end
`else
    assign range_bad = 1'b0;
`endif

    always_comb begin
        enc_inst = NOP;
        enc_bad  = 1'b0;
        case (in_op)
            OP_ADD:  enc_inst = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
            OP_SUB:  enc_inst = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
            OP_ADDI: enc_inst = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b0010011};
            OP_BNE:  enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b001,
                                 in_imm[4:1], in_imm[11], 7'b1100011};
            OP_JAL:  enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                 in_rd, 7'b1101111};
            OP_LUI:  enc_inst = {in_imm[31:12], in_rd, 7'b0110111};
            default: enc_bad  = 1'b1;
        endcase
        if (range_bad) begin
            enc_inst = NOP;
            enc_bad  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_addr  <= '0;
            word_cnt  <= '0;
            err       <= 1'b0;
            addr_cnt  <= BASE_ADDR;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_inst  <= enc_inst;
            out_addr  <= addr_now;
            addr_cnt  <= addr_now + ADDR_W'(4);
            if (clear)
                word_cnt <= 16'd1;
            else if (word_cnt != 16'hFFFF)
                word_cnt <= word_cnt + 16'd1;
            err <= (err && !clear) || enc_bad;
        end else begin
            if (out_ready)
                out_valid <= 1'b0;
            if (clear) begin
                addr_cnt <= BASE_ADDR;
                word_cnt <= '0;
                err      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inst_enc.sv
// Scoreboard bench for inst_enc: expected words and addresses are queued at stimulus
// time and popped by a monitor on every output handshake.
module tb_inst_enc;

    localparam int         AW   = 8;
    localparam logic [7:0] BASE = 8'h00;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_op = '0;
    logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [31:0]   in_imm = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [31:0]   out_inst;
    logic [AW-1:0] out_addr;
    logic [15:0]   word_cnt;
    logic          err;

    typedef struct {
        logic [31:0]   inst;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t          sb[$];
    logic [AW-1:0] exp_addr = BASE;
    int            checks = 0;
    int            errors = 0;
    bit            rand_ready = 0;
    bit            stall_prev = 0;
    logic [31:0]   hold_inst;
    logic [AW-1:0] hold_addr;

    inst_enc #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_addr(out_addr),
        .word_cnt(word_cnt), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    // Output monitor: stall stability and in-order scoreboard matching.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (out_valid !== 1'b1 || out_inst !== hold_inst || out_addr !== hold_addr) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b inst=%h addr=%h, want v=1 inst=%h addr=%h",
                             out_valid, out_inst, out_addr, hold_inst, hold_addr);
                end
            end
            stall_prev = out_valid && !out_ready;
            hold_inst  = out_inst;
            hold_addr  = out_addr;
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got inst=%h addr=%h, want none", out_inst, out_addr);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (out_inst !== e.inst || out_addr !== e.addr) begin
                        errors++;
                        $display("FAIL word: got inst=%h addr=%h, want inst=%h addr=%h",
                                 out_inst, out_addr, e.inst, e.addr);
                    end
                end
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm,
                        input logic [31:0] exp_inst, input bit with_clear);
        bit done = 0;
        if (with_clear) exp_addr = BASE;
        sb.push_back('{exp_inst, exp_addr});
        exp_addr = exp_addr + AW'(4);
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
        clear = with_clear;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        in_valid = 1'b0;
        clear = 1'b0;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout: got in_ready=0, want 1 within 200 cycles");
        end
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending, want 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        exp_addr = BASE;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic check_status(input string name, input logic [15:0] cnt, input logic e);
        checks++;
        if (word_cnt !== cnt || err !== e) begin
            errors++;
            $display("FAIL %s: got word_cnt=%0d err=%b, want word_cnt=%0d err=%b",
                     name, word_cnt, err, cnt, e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_inst !== 32'h0 || out_addr !== '0 ||
            word_cnt !== 16'h0 || err !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got v=%b inst=%h addr=%h cnt=%0d err=%b rdy=%b, want all 0, rdy=1",
                     out_valid, out_inst, out_addr, word_cnt, err, in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_addr = BASE;
    endtask

    task automatic test_add_sub();
        send(3'd0, 5'd3, 5'd1, 5'd2, 32'h0, 32'h002081B3, 0);
        send(3'd1, 5'd3, 5'd1, 5'd2, 32'h0, 32'h402081B3, 0);
        wait_drain();
        check_status("add_sub_cnt", 16'd2, 1'b0);
    endtask

    task automatic test_addi_lui();
        send(3'd2, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 0);
        send(3'd5, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 0);
        wait_drain();
        check_status("addi_lui_cnt", 16'd4, 1'b0);
    endtask

    task automatic test_bne_jal();
        send(3'd3, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 32'hFE209CE3, 0);
        send(3'd4, 5'd1, 5'd0, 5'd0, 32'd8, 32'h008000EF, 0);
        wait_drain();
        check_status("bne_jal_cnt", 16'd6, 1'b0);
    endtask

    task automatic test_back_to_back_stall();
        out_ready = 1'b0;
        send(3'd0, 5'd4, 5'd5, 5'd6, 32'h0, 32'h00628233, 0);
        in_op = 3'd1; in_rd = 5'd7; in_rs1 = 5'd8; in_rs2 = 5'd9; in_imm = '0;
        in_valid = 1'b1;
        sb.push_back('{32'h409403B3, exp_addr});
        exp_addr = exp_addr + AW'(4);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_inst !== 32'h00628233) begin
                errors++;
                $display("FAIL stall_state: got rdy=%b v=%b inst=%h, want rdy=0 v=1 inst=00628233",
                         in_ready, out_valid, out_inst);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_drain();
        check_status("stall_cnt", 16'd8, 1'b0);
    endtask

    task automatic test_illegal_clear();
        send(3'd7, 5'd3, 5'd1, 5'd2, 32'h0, 32'h00000013, 0);
        wait_drain();
        check_status("illegal_err", 16'd9, 1'b1);
        send(3'd0, 5'd3, 5'd1, 5'd2, 32'h0, 32'h002081B3, 0);
        wait_drain();
        check_status("err_sticky", 16'd10, 1'b1);
        pulse_clear();
        check_status("clear_state", 16'd0, 1'b0);
        send(3'd2, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 0);
        wait_drain();
        check_status("after_clear_cnt", 16'd1, 1'b0);
    endtask

    task automatic test_clear_capture();
        send(3'd0, 5'd3, 5'd1, 5'd2, 32'h0, 32'h002081B3, 0);
        send(3'd0, 5'd3, 5'd1, 5'd2, 32'h0, 32'h002081B3, 1);
        send(3'd1, 5'd3, 5'd1, 5'd2, 32'h0, 32'h402081B3, 0);
        wait_drain();
        check_status("clear_capture_cnt", 16'd2, 1'b0);
        send(3'd6, 5'd0, 5'd0, 5'd0, 32'h0, 32'h00000013, 1);
        wait_drain();
        check_status("clear_vs_err", 16'd1, 1'b1);
        pulse_clear();
    endtask

    task automatic test_range();
        logic [31:0] exp_w;
        logic        exp_e;
        send(3'd2, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFF00093, 0);
        wait_drain();
        check_status("addi_neg1", 16'd1, 1'b0);
`ifdef ENC_RANGE_CHECK_EN
        exp_w = 32'h00000013;
        exp_e = 1'b1;
`else
        exp_w = 32'h80000093;
        exp_e = 1'b0;
`endif
        send(3'd2, 5'd1, 5'd0, 5'd0, 32'd2048, exp_w, 0);
        wait_drain();
        check_status("addi_2048", 16'd2, exp_e);
        pulse_clear();
    endtask

    task automatic test_wrap_random();
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        rand_ready = 1;
        for (int i = 0; i < 70; i++) begin
            rd  = 5'(i);
            rs1 = 5'(i * 3);
            rs2 = 5'(i * 7);
            if (i % 3 == 2) begin
                imm = 32'(i) << 12;
                send(3'd5, rd, rs1, rs2, imm, {imm[31:12], rd, 7'b0110111}, 0);
            end else begin
                send(3'd0, rd, rs1, rs2, 32'h0, {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011}, 0);
            end
        end
        rand_ready = 0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        wait_drain();
        check_status("wrap_cnt", 16'd70, 1'b0);
        checks++;
        if (exp_addr !== 8'h18) begin
            errors++;
            $display("FAIL wrap_addr_model: got %h, want 18", exp_addr);
        end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        send(3'd0, 5'd3, 5'd1, 5'd2, 32'h0, 32'h002081B3, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_inst !== 32'h0 || word_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_drop: got v=%b inst=%h cnt=%0d, want v=0 inst=0 cnt=0",
                     out_valid, out_inst, word_cnt);
        end
        sb.delete();
        exp_addr = BASE;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send(3'd1, 5'd3, 5'd1, 5'd2, 32'h0, 32'h402081B3, 0);
        wait_drain();
        check_status("post_reset_cnt", 16'd1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_addi_lui();
        test_bne_jal();
        test_back_to_back_stall();
        test_illegal_clear();
        test_clear_capture();
        test_range();
        test_wrap_random();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_enc.md
Name: inst_enc

Overview:
- RV32I instruction encoder: the inverse of the core's instruction decode path.
- Accepts abstract micro-op fields (op, rd, rs1, rs2, imm) over a valid/ready handshake.
- Packs them into 32-bit instruction words and emits each word with its byte address, through a registered output stage with backpressure.
- Used by the boot/program loader and self-test logic to fill instruction memory for the ADD/SUB/ADDI/BNE/JAL/LUI subset the core decodes.

Parameters:
- ADDR_W, 32, width of the emitted byte address.
- BASE_ADDR, 0, address of the first emitted word after reset or clear.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  restart sequence: address counter to BASE_ADDR, err and word_cnt to 0.
- in_valid  input  1  fields valid.
- in_ready  output  1  encoder can accept fields this cycle.
- in_op  input  3  0=ADD, 1=SUB, 2=ADDI, 3=BNE, 4=JAL, 5=LUI, 6/7=illegal.
- in_rd  input  5  destination register.
- in_rs1  input  5  source register 1.
- in_rs2  input  5  source register 2.
- in_imm  input  32  immediate as a full signed byte value; for LUI, the full 32-bit constant.
- out_valid  output  1  out_inst/out_addr valid.
- out_ready  input  1  consumer accepts the word.
- out_inst  output  32  encoded instruction.
- out_addr  output  ADDR_W  byte address of out_inst.
- word_cnt  output  16  words accepted since reset/clear; saturates at 0xFFFF.
- err  output  1  sticky: illegal op (or range violation when enabled).

Behaviour:
- Reset (rst=1 at an edge):
  - out_valid=0, out_inst=0, out_addr=0, word_cnt=0, err=0.
  - Internal address counter = BASE_ADDR.
  - rst overrides every other input, including mid-transfer; a pending word is dropped.
- Handshake and latency:
  - in_ready = !out_valid || out_ready (combinational).
  - Capture occurs when in_valid && in_ready.
  - On capture, next cycle: out_valid=1, out_inst=encode(fields), out_addr=counter. Counter advances by 4, wrapping modulo 2^ADDR_W. word_cnt increments (saturating).
  - Latency is 1 cycle. Full throughput of 1 word/cycle while out_ready=1.
- Stall and drain:
  - While out_valid && !out_ready, out_inst, out_addr and out_valid hold stable.
  - If out_ready=1 and there is no capture, out_valid goes to 0.
- Encoding (opcode in [6:0]):
  - ADD: {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011}.
  - SUB: as ADD with funct7 = 7'b0100000.
  - ADDI: {imm[11:0], rs1, 3'b000, rd, 7'b0010011}.
  - BNE: {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], 7'b1100011}.
  - JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111}.
  - LUI: {imm[31:12], rd, 7'b0110111}.
  - Fields not used by an op are ignored.
  - Illegal op: out_inst = 32'h00000013 (NOP), err set to 1.
- Clear:
  - A clear cycle sets counter=BASE_ADDR, word_cnt=0, err=0.
  - Capture in the same cycle as clear: the word gets out_addr=BASE_ADDR, and afterwards counter=BASE_ADDR+4 and word_cnt=1.
  - err set by the same-cycle capture wins over clear.
  - clear does not drop a held output word.
- Address wrap: with counter=2^ADDR_W-4, the next word gets that address and the counter becomes 0. No flag is raised.
- Simultaneous capture and drain in one cycle: the old word is accepted by the consumer and the new word loads. No bubble.

Optional Feature:
- Macro ENC_RANGE_CHECK_EN.
- When defined, a capture with an unrepresentable immediate emits NOP 32'h00000013 and sets err. Unrepresentable means:
  - ADDI: imm[31:11] not all equal.
  - BNE: imm[31:12] not all equal, or imm[0]=1.
  - JAL: imm[31:20] not all equal, or imm[0]=1.
  - LUI: imm[11:0] != 0.
- When undefined, immediates are silently truncated per the encoding rules above, and err reflects illegal ops only.

Test Plan:
- Reset, then ADD rd=3 rs1=1 rs2=2, followed by SUB with the same fields, out_ready=1 -> 32'h002081B3 @ 0x0, then 32'h402081B3 @ 0x4; word_cnt=2.
- ADDI rd=1 rs1=0 imm=5; LUI rd=5 imm=32'h12345000 -> 32'h00500093, then 32'h123452B7 at consecutive addresses.
- BNE rs1=1 rs2=2 imm=-8; JAL rd=1 imm=8 -> 32'hFE209CE3, then 32'h008000EF.
- out_ready=0 with two back-to-back inputs -> first word held stable, in_ready=0, second input stalled. Raise out_ready -> both words emitted in order, no loss or duplication.
- in_op=7 -> out_inst=32'h00000013, err=1 and sticky. Then clear -> err=0, next word at BASE_ADDR.
- ADDI imm=2048 -> with ENC_RANGE_CHECK_EN: NOP and err=1; without it: 32'h80000093 (imm truncated to 12'h800, rd=1, rs1=0) and err=0.
